// File: rtl/frame_loader_if.sv
// Row-stream input and published-frame output bundle for frame_loader.
// Handshake: a row beat transfers on a posedge where in_valid and in_ready are both 1;
// in_row/in_sof must be held stable while in_valid=1 and in_ready=0.
interface frame_loader_if #(
  parameter int Row_Limit = 10
);
  localparam int IdxW = (Row_Limit > 1) ? $clog2(Row_Limit) : 1;

  logic [Row_Limit-1:0]           in_row;
  logic                           in_valid;
  logic                           in_sof;
  logic                           in_ready;
  logic [Row_Limit*Row_Limit-1:0] InData;
  logic                           frame_valid;
  logic                           frame_err;
  logic [7:0]                     frame_cnt;
  logic                           fsm_state;
  logic [IdxW-1:0]                row_idx;

  modport master (
    output in_row, in_valid, in_sof,
    input  in_ready, InData, frame_valid, frame_err, frame_cnt, fsm_state, row_idx
  );

  modport slave (
    input  in_row, in_valid, in_sof,
    output in_ready, InData, frame_valid, frame_err, frame_cnt, fsm_state, row_idx
  );
endinterface

// File: rtl/frame_loader.sv
// Assembles Row_Limit image rows into a shadow frame and publishes the whole frame
// atomically on InData, then holds it for HoldCycles cycles before refilling.
module frame_loader #(
  parameter int Row_Limit  = 10,
  parameter int HoldCycles = 2
) (
  input logic          clk,
  input logic          rst,
  frame_loader_if.slave bus
);
  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  localparam int IdxW   = (Row_Limit > 1) ? $clog2(Row_Limit) : 1;
  localparam int FrameW = Row_Limit * Row_Limit;

  state_t          state_q, state_d;
  logic [7:0]      hold_q, hold_d;
  logic [IdxW-1:0] row_idx_q, wr_idx;
  logic [FrameW-1:0] shadow_q, shadow_d, data_q;
  logic [7:0]      cnt_q;
  logic            err_q;
  logic            ready, accept, orphan, resync, wr_en, last;

  assign ready  = (state_q == FILL);
  assign accept = bus.in_valid && ready;

  // A sof beat always restarts at row 0; a non-sof beat with no frame in progress is dropped.
  always_comb begin
    wr_idx   = bus.in_sof ? '0 : row_idx_q;
    orphan   = accept && !bus.in_sof && (row_idx_q == '0);
    resync   = accept && bus.in_sof && (row_idx_q != '0);
    wr_en    = accept && !orphan;
    last     = wr_en && (wr_idx == IdxW'(Row_Limit - 1));
    shadow_d = shadow_q;
    if (wr_en) begin
      shadow_d[int'(wr_idx) * Row_Limit +: Row_Limit] = bus.in_row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      FILL: begin
        if (last) begin
          state_d = HOLD;
          hold_d  = 8'(HoldCycles);
        end
      end
      HOLD: begin
        if (hold_q <= 8'd1) begin
          state_d = FILL;
          hold_d  = '0;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      default: begin
        state_d = FILL;
        hold_d  = '0;
      end
    endcase
  end

  // The final row is merged straight from shadow_d so InData updates in one step.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_idx_q <= '0;
      shadow_q  <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= orphan || resync;
      if (wr_en) begin
        shadow_q <= shadow_d;
      end
      if (last) begin
        row_idx_q <= '0;
        data_q    <= shadow_d;
        cnt_q     <= cnt_q + 8'd1;
      end else if (wr_en) begin
        row_idx_q <= wr_idx + 1'b1;
      end
    end
  end

  assign bus.in_ready    = ready;
  assign bus.InData      = data_q;
  assign bus.frame_valid = (state_q == HOLD);
  assign bus.frame_err   = err_q;
  assign bus.frame_cnt   = cnt_q;
  assign bus.fsm_state   = state_q;
  assign bus.row_idx     = row_idx_q;
endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader: stimulus pushes expected frames/errors into queues,
// a negedge monitor pops and compares whenever the DUT publishes a frame or pulses an error.
module tb_frame_loader;
  localparam int RL = 10;
  localparam int HC = 2;
  localparam int FW = RL * RL;
  localparam int W  = FW + 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [W-1:0] exp_q[$];
  logic         err_q[$];
  logic [W-1:0] exp_w;
  logic [7:0]   exp_cnt = '0;

  logic fv_prev = 1'b0;
  int   run = 0;
  int   last_rise = -1;
  bit   period_chk = 1'b0;

  frame_loader_if #(.Row_Limit(RL)) bus ();

  frame_loader #(.Row_Limit(RL), .HoldCycles(HC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_row   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [RL-1:0] row, input logic sof);
    logic rdy;
    int   guard;
    bus.in_row   = row;
    bus.in_sof   = sof;
    bus.in_valid = 1'b1;
    rdy   = 1'b0;
    guard = 0;
    while (!rdy && guard < 100) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      guard++;
    end
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    check("beat_accepted", rdy, 1);
  endtask

  task automatic send_frame(input logic [FW-1:0] frm);
    for (int r = 0; r < RL; r++) begin
      if (r == RL - 1) begin
        exp_cnt = exp_cnt + 8'd1;
        exp_q.push_back({exp_cnt, frm});
      end
      send_beat(frm[r*RL +: RL], r == 0);
    end
  endtask

  task automatic check_cleared(input string tag);
    @(negedge clk);
    check({tag, "_indata"}, bus.InData, '0);
    check({tag, "_cnt"}, bus.frame_cnt, 0);
    check({tag, "_fv"}, bus.frame_valid, 0);
    check({tag, "_err"}, bus.frame_err, 0);
    check({tag, "_ready"}, bus.in_ready, 1);
    check({tag, "_row_idx"}, bus.row_idx, 0);
    check({tag, "_state"}, bus.fsm_state, 0);
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      fv_prev = 1'b0;
      run = 0;
    end else begin
      if (bus.frame_valid && !fv_prev) begin
        check("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          check("frame_data", {bus.frame_cnt, bus.InData}, exp_w);
        end
        if (period_chk && last_rise >= 0) check("frame_period", cyc - last_rise, RL + HC);
        last_rise = cyc;
      end
      if (bus.frame_valid) begin
        check("in_ready_hold", bus.in_ready, 0);
        run++;
      end
      if (!bus.frame_valid && fv_prev) begin
        check("hold_len", run, HC);
        run = 0;
      end
      if (bus.frame_err) begin
        check("err_expected", err_q.size() != 0, 1);
        if (err_q.size() != 0) void'(err_q.pop_front());
      end
      fv_prev = bus.frame_valid;
    end
  end

  // stimulus
  initial begin : stim
    logic [FW-1:0] frm;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_row   = '0;

    do_reset();
    check_cleared("reset");

    // orphan beats after reset
    for (int i = 0; i < 3; i++) begin
      err_q.push_back(1'b1);
      send_beat(RL'(10'h0F0 + i), 1'b0);
    end
    idle(2);
    check_cleared("orphan");

    // diagonal frame, back-to-back rows
    frm = '0;
    for (int r = 0; r < RL; r++) frm[r*RL + r] = 1'b1;
    send_frame(frm);
    idle(4);
    @(negedge clk);
    check("indata_kept_after_hold", bus.InData, frm);
    check("ready_after_hold", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // stalled rows of all ones after a fresh reset
    do_reset();
    for (int r = 0; r < RL; r++) begin
      if (r == RL - 1) begin
        exp_cnt = exp_cnt + 8'd1;
        exp_q.push_back({exp_cnt, {FW{1'b1}}});
      end
      send_beat({RL{1'b1}}, r == 0);
      if (r < RL - 1) begin
        @(negedge clk);
        check("stall_indata_zero", bus.InData, '0);
        @(posedge clk);
        #1;
      end
    end

    // resync: 4 rows, then a new sof restarts the frame
    for (int r = 0; r < 4; r++) send_beat(RL'(10'h2A0 + r), r == 0);
    frm = '0;
    frm[0 +: RL] = RL'(10'h155);
    for (int r = 1; r < RL; r++) frm[r*RL +: RL] = RL'(10'h0C0 + r);
    err_q.push_back(1'b1);
    send_frame(frm);
    idle(4);

    // reset at row 6 of the second frame
    do_reset();
    frm = '0;
    for (int r = 0; r < RL; r++) frm[r*RL +: RL] = RL'(10'h011 * (r + 1));
    send_frame(frm);
    for (int r = 0; r < 6; r++) send_beat(RL'(10'h3C0 + r), r == 0);
    do_reset();
    check_cleared("mid_fill_reset");
    idle(3);
    frm = '0;
    for (int r = 0; r < RL; r++) frm[r*RL +: RL] = RL'(10'h200 >> r) | RL'(r);
    send_frame(frm);
    idle(4);

    // last row and reset in the same cycle: reset wins
    do_reset();
    for (int r = 0; r < RL - 1; r++) send_beat(RL'(10'h1F0 + r), r == 0);
    bus.in_row   = RL'(10'h3AA);
    bus.in_sof   = 1'b0;
    bus.in_valid = 1'b1;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = '0;
    check_cleared("complete_vs_reset");

    // 256 back-to-back frames: counter wraps and the period is fixed
    do_reset();
    period_chk = 1'b1;
    last_rise  = -1;
    for (int k = 0; k < 256; k++) begin
      frm = '0;
      for (int r = 0; r < RL; r++) frm[r*RL +: RL] = RL'(k + r * 37);
      send_frame(frm);
    end
    idle(5);
    period_chk = 1'b0;
    @(negedge clk);
    check("wrap_cnt", bus.frame_cnt, 0);
    @(posedge clk);
    #1;

    idle(3);
    check("frames_outstanding", exp_q.size(), 0);
    check("errs_outstanding", err_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_loader.md
FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 Parameter Row_Limit, default 10, image side length in pixels; frame is Row_Limit x Row_Limit bits.
REQ-002 Parameter HoldCycles, default 2, cycles a completed frame is published before the next fill starts; legal range 1..255.
REQ-003 Port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 Port rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 Port in_row  input  Row_Limit  one image row; bit c is the pixel in column c.
REQ-006 Port in_valid  input  1  in_row/in_sof are valid this cycle.
REQ-007 Port in_sof  input  1  qualifies the current beat as row 0 of a new frame.
REQ-008 Port in_ready  output  1  loader accepts a row this cycle.
REQ-009 Port InData  output  Row_Limit*Row_Limit  published frame; bit r*Row_Limit+c is the pixel at row r, column c; feeds the pooling stage.
REQ-010 Port frame_valid  output  1  high while InData holds a newly completed frame (HOLD state).
REQ-011 Port frame_err  output  1  one-cycle pulse on a framing error.
REQ-012 Port frame_cnt  output  8  count of completed frames, modulo 256.

Function
REQ-013 A beat SHALL be accepted only in a cycle where in_valid and in_ready are both 1.
REQ-014 The FSM SHALL have two states: FILL (in_ready=1) and HOLD (in_ready=0).
REQ-015 In FILL, an accepted beat SHALL be written into an internal shadow frame at row index row_idx, and row_idx SHALL then increment.
REQ-016 An accepted beat with in_sof=1 SHALL be written as row 0 and SHALL set row_idx to 1, regardless of the prior row_idx.
REQ-017 If in_sof=1 is accepted while row_idx is not 0, frame_err SHALL pulse high for exactly one cycle, the following cycle.
REQ-018 An accepted beat with in_sof=0 while row_idx=0 SHALL be discarded, and frame_err SHALL pulse one cycle later; row_idx SHALL stay 0.
REQ-019 When the beat for row Row_Limit-1 is accepted, the next cycle SHALL:
  - copy the full shadow frame into InData in a single update;
  - enter HOLD with frame_valid=1;
  - reset row_idx to 0;
  - increment frame_cnt, wrapping 255->0.
REQ-020 InData SHALL change only on the cycle defined in REQ-019 and on reset; partial frames SHALL never be visible on InData.
REQ-021 HOLD SHALL last exactly HoldCycles cycles, using a down-counter loaded with HoldCycles on entry; the FSM SHALL then return to FILL with frame_valid=0.
REQ-022 Beats presented during HOLD SHALL be ignored (in_ready=0) and SHALL NOT raise frame_err.
REQ-023 InData SHALL keep its value after HOLD ends, until the next frame completes.
REQ-024 Minimum frame period SHALL be Row_Limit+HoldCycles cycles under continuous in_valid.
REQ-025 A rows-complete condition and rst in the same cycle SHALL resolve to reset.

Reset
REQ-026 While rst=1 at a clock edge, the next state SHALL be:
  - state FILL, row_idx=0, hold counter 0;
  - shadow frame and InData all zeros;
  - frame_valid=0, frame_err=0, frame_cnt=0;
  - in_ready=1 from the first cycle after rst deasserts.
REQ-027 Reset asserted mid-fill or mid-hold SHALL discard the partial frame, and SHALL NOT produce frame_valid or increment frame_cnt.

Verification
REQ-028 Row_Limit=10, HoldCycles=2; 10 consecutive beats, row r = 10'h001<<r, sof on beat 0 -> one cycle after beat 9, InData bit r*10+r=1 for r=0..9 and all other bits 0; frame_valid high for 2 cycles; frame_cnt=1; in_ready low for those 2 cycles.
REQ-029 Stall case: in_valid toggled 1/0 for 10 accepted rows of 10'h3FF -> InData stays all zeros until the completion cycle, then becomes all ones.
REQ-030 Resync: 4 rows sent, then in_sof beat -> frame_err pulses once; a further 9 rows (10 beats from the sof) complete the frame with the sof row as row 0.
REQ-031 Orphan beats: 3 beats with in_sof=0 after reset -> 3 frame_err pulses; row_idx stays 0; InData=0; frame_cnt=0.
REQ-032 Reset at row 6 of the 2nd frame -> InData=0, frame_cnt=0, no frame_valid; a following full frame gives frame_cnt=1.
REQ-033 Wrap: 256 back-to-back frames -> frame_cnt=0; frame period 12 cycles measured between frame_valid rising edges.
